layer_seq: RTL and testbench

Sequencer that runs the convolution layer block (`cnn_layer`) once per network layer. It captures an input feature map and issues one load pulse per layer with the layer index on `cs_layer`. After each layer it feeds the layer output back as the next layer's input, then reports the final map with a one-cycle `done`. It sits between the top-level host/DMA logic and a single shared `cnn_layer` instance.

---
 rtl/layer_seq_pkg.sv | 18 +
 rtl/layer_seq_relu.sv | 16 +
 rtl/layer_seq.sv | 132 +++++++++++++
 tb/tb_layer_seq.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/layer_seq_pkg.sv
// layer_seq_pkg: shared constants and state encoding for the layer sequencer.
// DATA_LEN is the signed element width of the feature-map data.
package layer_seq_pkg;

  localparam int DATA_LEN = 16;

  // Width of the layer index presented to cnn_layer (up to 8 layers).
  localparam int CS_W = 3;

  typedef enum logic [2:0] {
    LS_IDLE = 3'd0,
    LS_LOAD = 3'd1,
    LS_WAIT = 3'd2,
    LS_CAPT = 3'd3,
    LS_DONE = 3'd4
  } ls_state_e;

endpackage

// File: rtl/layer_seq_relu.sv
// relu_vec: element-wise ReLU over a packed vector of signed elements.
// Negative elements (sign bit set) become zero; others pass unchanged.
module relu_vec #(
  parameter int N_ELEM = 1,
  parameter int ELEM_W = 8
) (
  input  logic [N_ELEM*ELEM_W-1:0] i_d,
  output logic [N_ELEM*ELEM_W-1:0] o_q
);

  for (genvar gi = 0; gi < N_ELEM; gi++) begin : g_elem
    assign o_q[gi*ELEM_W +: ELEM_W] =
      i_d[gi*ELEM_W + ELEM_W - 1] ? '0 : i_d[gi*ELEM_W +: ELEM_W];
  end

endmodule

// File: rtl/layer_seq.sv
// layer_seq: runs a shared cnn_layer once per network layer, feeding each
// layer's output back as the next layer's input, and pulses done when the
// final map sits in result.
// Optional build macro LAYER_SEQ_RELU_EN: clamp negative elements to zero on
// every intermediate capture (the last layer's output is stored raw).
module layer_seq
  import layer_seq_pkg::*;
#(
  parameter int NUM_LAYERS = 4,
  parameter int FMAP_W     = 32*12*DATA_LEN
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [FMAP_W-1:0] in_d,
  output logic              layer_load,
  output logic [CS_W-1:0]   cs_layer,
  output logic [FMAP_W-1:0] layer_d,
  input  logic              layer_valid,
  input  logic [FMAP_W-1:0] layer_q,
  output logic              busy,
  output logic              done,
  output logic [FMAP_W-1:0] result
);

  ls_state_e         r_state;
  ls_state_e         w_next;
  logic [CS_W-1:0]   r_cnt;
  logic [FMAP_W-1:0] r_fmap;
  logic [FMAP_W-1:0] w_capt;
  logic              r_vld_d;
  logic              w_edge;
  logic              w_last;
  logic              w_ld_start;
  logic              w_ld_capt;
  logic              w_cnt_clr;
  logic              w_cnt_inc;

  // A level left high by the previous layer is not a completion.
  assign w_edge = layer_valid & ~r_vld_d;
  assign w_last = (r_cnt == CS_W'(NUM_LAYERS - 1));

`ifdef LAYER_SEQ_RELU_EN
  logic [FMAP_W-1:0] w_relu;

  relu_vec #(
    .N_ELEM (FMAP_W / DATA_LEN),
    .ELEM_W (DATA_LEN)
  ) u_relu (
    .i_d (layer_q),
    .o_q (w_relu)
  );

  assign w_capt = w_last ? layer_q : w_relu;
`else
  assign w_capt = layer_q;
`endif

  // Next-state and datapath control; abort outranks every other transition.
  always_comb begin
    w_next     = r_state;
    w_ld_start = 1'b0;
    w_ld_capt  = 1'b0;
    w_cnt_clr  = 1'b0;
    w_cnt_inc  = 1'b0;
    if ((r_state != LS_IDLE) && abort) begin
      w_next    = LS_IDLE;
      w_cnt_clr = 1'b1;
    end else begin
      case (r_state)
        LS_IDLE: begin
          if (start) begin
            w_next     = LS_LOAD;
            w_ld_start = 1'b1;
            w_cnt_clr  = 1'b1;
          end
        end
        LS_LOAD: w_next = LS_WAIT;
        LS_WAIT: begin
          if (w_edge) w_next = LS_CAPT;
        end
        LS_CAPT: begin
          w_ld_capt = 1'b1;
          if (w_last) begin
            w_next = LS_DONE;
          end else begin
            w_next    = LS_LOAD;
            w_cnt_inc = 1'b1;
          end
        end
        LS_DONE: begin
          w_next    = LS_IDLE;
          w_cnt_clr = 1'b1;
        end
        default: begin
          w_next    = LS_IDLE;
          w_cnt_clr = 1'b1;
        end
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= LS_IDLE;
    else        r_state <= w_next;
  end

  // Feature map, layer counter and layer_valid history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fmap  <= '0;
      r_cnt   <= '0;
      r_vld_d <= 1'b0;
    end else begin
      r_vld_d <= layer_valid;
      if (w_ld_start)     r_fmap <= in_d;
      else if (w_ld_capt) r_fmap <= w_capt;
      if (w_cnt_clr)      r_cnt  <= '0;
      else if (w_cnt_inc) r_cnt  <= r_cnt + CS_W'(1);
    end
  end

  assign layer_load = (r_state == LS_LOAD);
  assign busy       = (r_state != LS_IDLE);
  assign done       = (r_state == LS_DONE);
  assign cs_layer   = r_cnt;
  assign layer_d    = r_fmap;
  assign result     = r_fmap;

endmodule

// File: tb/tb_layer_seq.sv
// tb_layer_seq: directed-plus-random bench for layer_seq with a behavioural
// layer stand-in (q = d + delta per element after lat cycles, valid held high
// until the next load). Two instances: 4 layers and 1 layer, selected by sel.
module tb_layer_seq;
  import layer_seq_pkg::*;

  localparam int DL     = DATA_LEN;
  localparam int FMAP_W = 32*12*DL;
  localparam int NE     = FMAP_W / DL;
`ifdef LAYER_SEQ_RELU_EN
  localparam bit RELU = 1'b1;
`else
  localparam bit RELU = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n, start, abort, sel;
  logic [FMAP_W-1:0] in_d;
  int                delta, lat;
  int                n_vec = 0, n_err = 0;
  logic [FMAP_W-1:0] exp_map [0:8];

  logic              a_start, a_abort, a_load, a_vld, a_busy, a_done;
  logic [CS_W-1:0]   a_cs;
  logic [FMAP_W-1:0] a_d, a_q, a_res, a_src;
  int                a_cnt;
  logic              b_start, b_abort, b_load, b_vld, b_busy, b_done;
  logic [CS_W-1:0]   b_cs;
  logic [FMAP_W-1:0] b_d, b_q, b_res, b_src;
  int                b_cnt;

  logic              w_load, w_busy, w_done;
  logic [CS_W-1:0]   w_cs;
  logic [FMAP_W-1:0] w_ld, w_res;

  assign a_start = start & ~sel;
  assign b_start = start & sel;
  assign a_abort = abort & ~sel;
  assign b_abort = abort & sel;
  assign w_load  = sel ? b_load : a_load;
  assign w_busy  = sel ? b_busy : a_busy;
  assign w_done  = sel ? b_done : a_done;
  assign w_cs    = sel ? b_cs   : a_cs;
  assign w_ld    = sel ? b_d    : a_d;
  assign w_res   = sel ? b_res  : a_res;

  layer_seq #(.NUM_LAYERS(4), .FMAP_W(FMAP_W)) u_a (
    .clk(clk), .rst_n(rst_n), .start(a_start), .abort(a_abort), .in_d(in_d),
    .layer_load(a_load), .cs_layer(a_cs), .layer_d(a_d), .layer_valid(a_vld),
    .layer_q(a_q), .busy(a_busy), .done(a_done), .result(a_res));

  layer_seq #(.NUM_LAYERS(1), .FMAP_W(FMAP_W)) u_b (
    .clk(clk), .rst_n(rst_n), .start(b_start), .abort(b_abort), .in_d(in_d),
    .layer_load(b_load), .cs_layer(b_cs), .layer_d(b_d), .layer_valid(b_vld),
    .layer_q(b_q), .busy(b_busy), .done(b_done), .result(b_res));

  function automatic logic [FMAP_W-1:0] layer_fn(input logic [FMAP_W-1:0] d, input int dl);
    logic [FMAP_W-1:0] q;
    for (int e = 0; e < NE; e++) q[e*DL +: DL] = d[e*DL +: DL] + DL'(dl);
    return q;
  endfunction

  // Layer stand-ins for both instances.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_vld <= 1'b0; a_cnt <= 0; a_q <= '0; a_src <= '0;
    end else if (a_load) begin
      a_vld <= 1'b0; a_cnt <= lat; a_src <= a_d;
    end else if (a_cnt != 0) begin
      a_cnt <= a_cnt - 1;
      if (a_cnt == 1) begin a_vld <= 1'b1; a_q <= layer_fn(a_src, delta); end
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b_vld <= 1'b0; b_cnt <= 0; b_q <= '0; b_src <= '0;
    end else if (b_load) begin
      b_vld <= 1'b0; b_cnt <= lat; b_src <= b_d;
    end else if (b_cnt != 0) begin
      b_cnt <= b_cnt - 1;
      if (b_cnt == 1) begin b_vld <= 1'b1; b_q <= layer_fn(b_src, delta); end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_vec++;
    assert (obs === want) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  task automatic chk_map(input string tag, input logic [FMAP_W-1:0] obs, input logic [FMAP_W-1:0] want);
    n_vec++;
    assert (obs === want) else begin
      n_err++;
      $error("FAIL %s: observed[63:0] %h expected[63:0] %h", tag, obs[63:0], want[63:0]);
    end
  endtask

  // Expected map entering each layer, plus the final map at index n.
  task automatic build_ref(input logic [FMAP_W-1:0] din, input int d, input int n);
    logic [FMAP_W-1:0] m;
    logic signed [DL-1:0] t;
    int v;
    m = din;
    exp_map[0] = m;
    for (int k = 0; k < n; k++) begin
      for (int e = 0; e < NE; e++) begin
        v = int'($signed(m[e*DL +: DL])) + d;
        t = v[DL-1:0];
        if (RELU && (k < n - 1) && (t < 0)) t = '0;
        m[e*DL +: DL] = t;
      end
      exp_map[k+1] = m;
    end
  endtask

  function automatic logic [FMAP_W-1:0] rand_map();
    logic [FMAP_W-1:0] m;
    for (int i = 0; i < FMAP_W/32; i++) m[i*32 +: 32] = $urandom;
    return m;
  endfunction

  function automatic logic [FMAP_W-1:0] fill_map(input int val);
    logic [FMAP_W-1:0] m;
    for (int e = 0; e < NE; e++) m[e*DL +: DL] = DL'(val);
    return m;
  endfunction

  task automatic start_run(input logic [FMAP_W-1:0] din, input int d, input int l);
    delta = d;
    lat   = l;
    @(negedge clk);
    in_d  = din;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    in_d  = ~din;
  endtask

  // Full run with a stray start pulse while busy.
  task automatic run(input logic [FMAP_W-1:0] din, input int d, input int l, input int n);
    int loads, done_cyc, spur;
    loads    = 0;
    done_cyc = 0;
    spur     = $urandom_range(2, 4);
    build_ref(din, d, n);
    start_run(din, d, l);
    for (int c = 1; c <= 400; c++) begin
      if (c == 1) chk("busy_cycle1", 32'(w_busy), 1);
      if (w_done) begin
        done_cyc = c;
        break;
      end
      if (w_load) begin
        chk("cs_at_load", 32'(w_cs), loads);
        if (loads <= 8) chk_map("layer_d_at_load", w_ld, exp_map[loads]);
        loads++;
      end else if (loads > 0 && loads <= 8) begin
        chk_map("layer_d_hold", w_ld, exp_map[loads-1]);
        chk("cs_hold", 32'(w_cs), loads - 1);
      end
      start = (c == spur);
      if (start) in_d = rand_map();
      @(negedge clk);
      start = 1'b0;
    end
    start = 1'b0;
    chk("done_seen", 32'(done_cyc != 0), 1);
    chk("load_count", loads, n);
    chk("done_cycle", done_cyc, n*(l+3)+1);
    chk_map("result", w_res, exp_map[n]);
    @(negedge clk);
    chk("done_one_cycle", 32'(w_done), 0);
    chk("busy_after", 32'(w_busy), 0);
    chk("cs_idle", 32'(w_cs), 0);
    chk_map("result_hold", w_res, exp_map[n]);
  endtask

  task automatic wait_load_cs(input int idx);
    int got;
    got = 0;
    for (int c = 0; c < 200; c++) begin
      if (w_load && (w_cs == CS_W'(idx))) begin got = 1; break; end
      @(negedge clk);
    end
    chk("reach_layer", got, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [FMAP_W-1:0] din;
    int dn;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; sel = 1'b0;
    in_d  = '0;   delta = 1;    lat   = 5;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_load", 32'(a_load), 0);
    chk("rst_cs", 32'(a_cs), 0);
    chk("rst_busy", 32'(a_busy), 0);
    chk("rst_done", 32'(a_done), 0);
    chk_map("rst_result", a_res, '0);
    rst_n = 1'b1;

    // Directed: zero map, +1 per layer, latency 5.
    run('0, 1, 5, 4);
    // Directed: all-ones map, -3 per layer (clamps when ReLU is built in).
    run(fill_map(1), -3, 5, 4);
    // Random maps, offsets and latencies.
    for (int i = 0; i < 4; i++)
      run(rand_map(), int'($urandom_range(0, 10)) - 5, int'($urandom_range(1, 6)), 4);

    // Abort in the WAIT state of layer 2.
    din = rand_map();
    build_ref(din, 1, 4);
    start_run(din, 1, 5);
    wait_load_cs(2);
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", 32'(a_busy), 0);
    chk("abort_cs", 32'(a_cs), 0);
    chk("abort_load", 32'(a_load), 0);
    chk_map("abort_result", a_res, exp_map[2]);
    dn = 0;
    for (int c = 0; c < 12; c++) begin
      if (a_done || a_busy) dn = 1;
      @(negedge clk);
    end
    chk("abort_quiet", dn, 0);
    run(rand_map(), 2, 3, 4);

    // Reset dropped in the WAIT state of layer 1.
    din = rand_map();
    start_run(din, 1, 5);
    wait_load_cs(1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mrst_load", 32'(a_load), 0);
    chk("mrst_cs", 32'(a_cs), 0);
    chk("mrst_busy", 32'(a_busy), 0);
    chk("mrst_done", 32'(a_done), 0);
    chk_map("mrst_result", a_res, '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run(rand_map(), -1, 4, 4);

    // Single-layer instance.
    sel = 1'b1;
    run('0, 1, 5, 1);
    run(rand_map(), int'($urandom_range(0, 10)) - 5, int'($urandom_range(1, 6)), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
